stopwatch_ascii_frame_receiver: RTL
===================================

Name: stopwatch_ascii_frame_receiver

Overview:
- Receive-side counterpart of the stopwatch ASCII transmit path.
- Drains bytes from the UART RX FIFO and parses fixed-format time frames "D3 D2 '.' D1 D0 CR LF".
- Validates each frame, then presents the four BCD digits to a display or compare stage (e.g. a second board mirroring the stopwatch).
- Malformed or stalled frames raise an error pulse; the parser then resynchronises on the next LF.

Parameters:
TIMEOUT_CYCLES, 10_000_000, max idle clocks between bytes inside a frame before abort (100 ms at 100 MHz)
SEP_CHAR, 8'h2E, separator byte expected between D2 and D1 ('.')

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_rx_empty  in  1  RX FIFO empty flag
i_rd_data  in  8  RX FIFO head byte; valid while i_rx_empty=0 (first-word-fall-through)
o_rd_uart  out  1  FIFO pop strobe
o_d3  out  4  committed BCD digit 3 (most significant)
o_d2  out  4  committed BCD digit 2
o_d1  out  4  committed BCD digit 1
o_d0  out  4  committed BCD digit 0
o_frame_tick  out  1  one-cycle pulse: new valid frame committed
o_err_tick  out  1  one-cycle pulse: frame aborted
o_err_code  out  2  01 = unexpected byte, 10 = inter-byte timeout; holds last code
o_busy  out  1  1 while a frame is partially received (states D2..LF)

Behaviour:
- Clocking/reset: all state on i_clk rising edge. i_reset clears FSM to IDLE, staging digits and outputs o_d3..o_d0 to 0, o_frame_tick/o_err_tick to 0, o_err_code to 00, timeout counter to 0.
- Reset mid-frame: the partial frame is discarded silently; no err pulse.
- Pop handshake: o_rd_uart = ~i_rx_empty & ~i_reset (combinational). A byte is consumed in any cycle with o_rd_uart=1. At most one byte per clock; the block never back-pressures.
- Digit: byte in 8'h30..8'h39; value = byte[3:0].
- FSM states: IDLE, GOT_D3, GOT_D2, GOT_SEP, GOT_D1, GOT_D0, GOT_CR, HUNT. Transitions on a consumed byte:
  - IDLE: digit -> stage d3, GOT_D3. CR or LF -> stay IDLE (blank lines ignored). Other -> err 01, HUNT.
  - GOT_D3: digit -> stage d2, GOT_D2. Other -> err 01.
  - GOT_D2: SEP_CHAR -> GOT_SEP. Other -> err 01.
  - GOT_SEP: digit -> stage d1, GOT_D1. Other -> err 01.
  - GOT_D1: digit -> stage d0, GOT_D0. Other -> err 01.
  - GOT_D0: CR -> GOT_CR. Other -> err 01.
  - GOT_CR: LF -> commit staged digits to o_d3..o_d0, pulse o_frame_tick, IDLE. Other -> err 01.
  - HUNT: LF -> IDLE; any other byte is discarded with no further error pulses.
- Unexpected-byte error (code 01): whenever a state rejects a byte, the FSM enters HUNT. Exception: if the offending byte is itself LF, the FSM goes directly to IDLE.
- Latency: o_frame_tick and the new digit values appear on the edge after the cycle LF is consumed (1 cycle). The digits hold until the next valid frame; errors never modify o_d*.
- Error signalling: o_err_tick is a one-cycle pulse registered on the same edge as the transition. o_err_code updates on that same edge.
- Timeout:
  - Counter width $clog2(TIMEOUT_CYCLES+1). Cleared on every consumed byte and whenever the state is IDLE or HUNT.
  - Otherwise increments each cycle with i_rx_empty=1.
  - On reaching TIMEOUT_CYCLES: err 10, discard staging, go to IDLE (not HUNT).
  - A byte consumed in the same cycle the counter would expire takes priority; no timeout occurs.
- Back-to-back frames: a digit arriving the cycle right after LF is accepted normally. Zero dead cycles are required.
- o_busy = state not in {IDLE, HUNT}.

Decomposition:
- Shared package/header holds the ASCII constants (CHAR_0, CHAR_9, CHAR_CR=8'h0D, CHAR_LF=8'h0A, default SEP_CHAR), the state encodings, and the err code constants (ERR_NONE, ERR_CHAR, ERR_TIMEOUT).
- One natural sub-module: frame_timeout_counter (clear/enable in, expire out, parameterised by TIMEOUT_CYCLES).
- Digit decode stays inline.

Test Plan:
- FIFO presents "12.34\r\n" one byte per cycle -> 7 pops; o_frame_tick high exactly once, one cycle after the LF pop; o_d3..o_d0 = 1,2,3,4; o_err_tick never asserts.
- "12x" then "99\n" then "56.78\r\n" -> o_err_tick once with code 01 on 'x'; "99\n" is swallowed in HUNT; final digits = 5,6,7,8 with one frame_tick.
- "\r\n\r\n09.87\r\n" -> leading CR/LF ignored with no error; digits 0,9,8,7.
- Bench TIMEOUT_CYCLES=16: "12." then FIFO empty for 20 cycles -> err code 10 exactly 16 idle cycles after the '.' pop; then "34.56\r\n" -> digits 3,4,5,6.
- Assert i_reset for 1 cycle after "12.3" of a frame -> all outputs 0 and no err pulse; then a full "00.01\r\n" -> digits 0,0,0,1.
- Two frames "11.11\r\n22.22\r\n" with FIFO never empty -> 14 consecutive pops, two frame_ticks exactly 7 cycles apart; final digits 2,2,2,2.

Source files
------------

// File: rtl/stopwatch_ascii_frame_receiver_pkg.sv
// stopwatch_ascii_frame_receiver_pkg: ASCII constants, parser states and error codes
package stopwatch_ascii_frame_receiver_pkg;
    localparam logic [7:0] CHAR_0   = 8'h30;
    localparam logic [7:0] CHAR_9   = 8'h39;
    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_SEP = 8'h2E;
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CHAR    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    typedef enum logic [2:0] {
        IDLE, GOT_D3, GOT_D2, GOT_SEP, GOT_D1, GOT_D0, GOT_CR, HUNT
    } state_t;
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CHAR_0) && (b <= CHAR_9);
    endfunction
endpackage

// File: rtl/stopwatch_ascii_frame_receiver_if.sv
// stopwatch_ascii_frame_receiver_if: first-word-fall-through RX FIFO read port
interface stopwatch_ascii_frame_receiver_if;
    logic       rx_empty;
    logic [7:0] rd_data;
    logic       rd_uart;
    modport master(output rx_empty, rd_data, input rd_uart);
    modport slave(input rx_empty, rd_data, output rd_uart);
endinterface

// File: rtl/stopwatch_ascii_frame_receiver_frame_timeout_counter.sv
// stopwatch_ascii_frame_receiver_frame_timeout_counter: counts idle cycles inside a frame, flags expiry
module stopwatch_ascii_frame_receiver_frame_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt;
    // expiry fires during the idle cycle that would bring the count to TIMEOUT_CYCLES
    assign expire = enable & ~clear & (cnt == W'(TIMEOUT_CYCLES - 1));
    // idle-cycle counter; restarts on any consumed byte, outside a frame, or after expiry
    always_ff @(posedge i_clk) begin
        if (i_reset || clear || expire)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/stopwatch_ascii_frame_receiver.sv
// stopwatch_ascii_frame_receiver: parses "D3D2.D1D0\r\n" frames from the RX FIFO into BCD digits
module stopwatch_ascii_frame_receiver
    import stopwatch_ascii_frame_receiver_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 10_000_000,
    parameter logic [7:0] SEP_CHAR       = CHAR_SEP
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    stopwatch_ascii_frame_receiver_if.slave    rx,
    output logic [3:0]                         o_d3,
    output logic [3:0]                         o_d2,
    output logic [3:0]                         o_d1,
    output logic [3:0]                         o_d0,
    output logic                               o_frame_tick,
    output logic                               o_err_tick,
    output logic [1:0]                         o_err_code,
    output logic                               o_busy
);
    state_t      state, state_n;
    logic [15:0] stage, stage_n, dig, dig_n;
    logic [1:0]  code, code_n;
    logic        frame_n, err_n, reject, pop, expire, dv, cr, lf;
    logic [7:0]  b;

    assign pop         = ~rx.rx_empty & ~i_reset;
    assign rx.rd_uart  = pop;
    assign b           = rx.rd_data;
    assign dv          = is_digit(b);
    assign cr          = b == CHAR_CR;
    assign lf          = b == CHAR_LF;
    assign o_busy      = (state != IDLE) && (state != HUNT);
    assign {o_d3, o_d2, o_d1, o_d0} = dig;
    assign o_err_code  = code;

    stopwatch_ascii_frame_receiver_frame_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .clear  (pop | ~o_busy),
        .enable (rx.rx_empty),
        .expire (expire)
    );

    // next-state, staging and pulse decode for one consumed byte or a timeout
    always_comb begin
        state_n = state;
        stage_n = stage;
        dig_n   = dig;
        code_n  = code;
        frame_n = 1'b0;
        err_n   = 1'b0;
        reject  = 1'b0;
        if (expire) begin
            state_n = IDLE;
            stage_n = '0;
            err_n   = 1'b1;
            code_n  = ERR_TIMEOUT;
        end else if (pop) begin
            case (state)
                IDLE: begin
                    if (dv) begin
                        stage_n[15:12] = b[3:0];
                        state_n = GOT_D3;
                    end else if (!(cr || lf)) reject = 1'b1;
                end
                GOT_D3: begin
                    if (dv) begin
                        stage_n[11:8] = b[3:0];
                        state_n = GOT_D2;
                    end else reject = 1'b1;
                end
                GOT_D2: begin
                    if (b == SEP_CHAR) state_n = GOT_SEP;
                    else reject = 1'b1;
                end
                GOT_SEP: begin
                    if (dv) begin
                        stage_n[7:4] = b[3:0];
                        state_n = GOT_D1;
                    end else reject = 1'b1;
                end
                GOT_D1: begin
                    if (dv) begin
                        stage_n[3:0] = b[3:0];
                        state_n = GOT_D0;
                    end else reject = 1'b1;
                end
                GOT_D0: begin
                    if (cr) state_n = GOT_CR;
                    else reject = 1'b1;
                end
                GOT_CR: begin
                    if (lf) begin
                        dig_n   = stage;
                        frame_n = 1'b1;
                        state_n = IDLE;
                    end else reject = 1'b1;
                end
                HUNT: begin
                    if (lf) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
            if (reject) begin
                state_n = lf ? IDLE : HUNT;
                err_n   = 1'b1;
                code_n  = ERR_CHAR;
            end
        end
    end

    // state, staging, committed digits and registered pulses
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            stage        <= '0;
            dig          <= '0;
            code         <= ERR_NONE;
            o_frame_tick <= 1'b0;
            o_err_tick   <= 1'b0;
        end else begin
            state        <= state_n;
            stage        <= stage_n;
            dig          <= dig_n;
            code         <= code_n;
            o_frame_tick <= frame_n;
            o_err_tick   <= err_n;
        end
    end
endmodule
